// File: rtl/logger_pkg.sv
// Shared debug-log types: FSM states, command priority and the metadata layout used by the read side.
// FULL state exists only when LOGGER_STOP_ON_FULL_EN is defined.
package logger_pkg;

`ifdef LOGGER_STOP_ON_FULL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOGGING = 2'd1, FULL = 2'd2} log_state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOGGING = 2'd1} log_state_e;
`endif

  localparam int LOG_DATA_W = 64;

  typedef enum logic [1:0] {CMD_NONE, CMD_START, CMD_STOP, CMD_CLEAR} log_cmd_e;

  // Coincident pulses resolve as clear > stop > start.
  function automatic log_cmd_e log_cmd_decode(input logic start, input logic stop,
                                              input logic clear);
    log_cmd_e cmd;
    cmd = CMD_NONE;
    if (clear)      cmd = CMD_CLEAR;
    else if (stop)  cmd = CMD_STOP;
    else if (start) cmd = CMD_START;
    return cmd;
  endfunction

  // Read-side metadata word: has_wrapped at bit addr_w, write pointer in bits addr_w-1:0.
  function automatic logic [31:0] log_meta_pack(input logic wrapped, input logic [30:0] addr,
                                                input int unsigned addr_w);
    logic [31:0] meta;
    meta = {1'b0, addr} & ((32'd1 << addr_w) - 32'd1);
    meta[addr_w] = wrapped;
    return meta;
  endfunction

endpackage

// File: rtl/logger_sample_timer.sv
// Sample-interval counter: sample_tick is combinational, high when the count equals sample_interval.
// Count is cleared whenever en is low; no backpressure.
module logger_sample_timer
  import logger_pkg::*;
#(
  parameter int INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [INTERVAL_W-1:0] sample_interval,
  output logic                  sample_tick
);

  logic [INTERVAL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sample_tick = 1'b0;
    cnt_d       = '0;
    if (en) begin
      if (cnt_q == sample_interval) begin
        sample_tick = 1'b1;
      end else begin
        cnt_d = cnt_q + INTERVAL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/logger_log_writer.sv
// Debug-log write controller: samples entries every sample_interval+1 cycles into a circular RAM, one-cycle write latency, no backpressure.
// Define LOGGER_STOP_ON_FULL_EN for one-shot capture that halts in FULL after writing the last address.
module logger_log_writer
  import logger_pkg::*;
#(
  parameter int LOG_ADDR_W = 13,
  parameter int INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  log_start,
  input  logic                  log_stop,
  input  logic                  log_clear,
  input  logic [INTERVAL_W-1:0] sample_interval,
  input  logic                  log_entry_val,
  input  logic [LOG_DATA_W-1:0] log_entry_data,
  output logic                  log_wr_req_val,
  output logic [LOG_ADDR_W-1:0] log_wr_req_addr,
  output logic [LOG_DATA_W-1:0] log_wr_req_data,
  output logic [LOG_ADDR_W-1:0] curr_log_wr_addr,
  output logic                  has_wrapped,
  output logic                  logging_active
);

  log_state_e            state_q, state_d;
  logic [LOG_ADDR_W-1:0] ptr_q, ptr_d;
  logic                  wrapped_q, wrapped_d;
  logic                  wr_val_q, wr_val_d;
  logic [LOG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LOG_DATA_W-1:0] wr_data_q, wr_data_d;
  log_cmd_e              cmd;
  logic                  timer_en;
  logic                  sample_tick;

  assign cmd = log_cmd_decode(log_start, log_stop, log_clear);

  // A stop or clear in this cycle suppresses the sample and restarts the count.
  assign timer_en = (state_q == LOGGING) && (cmd != CMD_STOP) && (cmd != CMD_CLEAR);

  logger_sample_timer #(
    .INTERVAL_W(INTERVAL_W)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .en             (timer_en),
    .sample_interval(sample_interval),
    .sample_tick    (sample_tick)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wrapped_d = wrapped_q;
    wr_val_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (sample_tick && log_entry_val) begin
      wr_val_d  = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = log_entry_data;
      ptr_d     = ptr_q + LOG_ADDR_W'(1);
      if (&ptr_q) begin
        wrapped_d = 1'b1;
`ifdef LOGGER_STOP_ON_FULL_EN
        state_d = FULL;
`endif
      end
    end

    case (cmd)
      CMD_CLEAR: begin
        state_d   = IDLE;
        ptr_d     = '0;
        wrapped_d = 1'b0;
      end
      CMD_STOP: begin
        if (state_q == LOGGING) state_d = IDLE;
      end
      CMD_START: begin
        if (state_q == IDLE) state_d = LOGGING;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      wrapped_q <= 1'b0;
      wr_val_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wrapped_q <= wrapped_d;
      wr_val_q  <= wr_val_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign log_wr_req_val   = wr_val_q;
  assign log_wr_req_addr  = wr_addr_q;
  assign log_wr_req_data  = wr_data_q;
  assign curr_log_wr_addr = ptr_q;
  assign has_wrapped      = wrapped_q;
  assign logging_active   = (state_q == LOGGING);

endmodule

// File: doc/logger_log_writer.md
# logger_log_writer

Write-side controller for the on-chip debug log. Samples a 64-bit log entry at a programmable interval while logging is enabled and writes it into the circular log RAM. Exports the current write pointer and a sticky wrap flag, which the log read path reports as metadata. Sits between the monitored datapath or counters and the log RAM write port.

## Interface
Parameters:
- LOG_ADDR_W, 13, log RAM address width; depth is 2^LOG_ADDR_W entries
- INTERVAL_W, 16, width of the sample-interval counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- log_start  in  1  pulse: begin logging
- log_stop  in  1  pulse: stop logging; pointer and wrap flag are kept
- log_clear  in  1  pulse: stop logging and zero the pointer and wrap flag
- sample_interval  in  INTERVAL_W  a sample opportunity occurs every sample_interval+1 cycles
- log_entry_val  in  1  log_entry_data is valid this cycle
- log_entry_data  in  64  entry to record
- log_wr_req_val  out  1  RAM write strobe
- log_wr_req_addr  out  LOG_ADDR_W  RAM write address
- log_wr_req_data  out  64  RAM write data
- curr_log_wr_addr  out  LOG_ADDR_W  next address to be written
- has_wrapped  out  1  sticky: the pointer has wrapped at least once since the last clear
- logging_active  out  1  high while in state LOGGING

## Operation
- State machine (enum in package):
  - IDLE -> LOGGING on log_start.
  - LOGGING -> IDLE on log_stop.
  - Any state -> IDLE on log_clear.
  - FULL exists only with the macro defined (see Configuration).
- Command priority when pulses coincide: log_clear > log_stop > log_start.
- log_start in LOGGING is ignored. log_start in IDLE zeroes the interval counter and keeps the pointer, so logging appends after a stop.
- Interval counter, in LOGGING only:
  - When the counter equals sample_interval, the cycle is a sample opportunity and the counter returns to 0. Otherwise it increments.
  - The counter holds at 0 outside LOGGING.
  - sample_interval is read live. If the counter exceeds a newly lowered value, it counts up and wraps naturally; no special case is required.
- Sample opportunity with log_entry_val=1 records the entry. With log_entry_val=0 the opportunity is skipped and no write occurs.
- Recording an entry:
  - The write address is wr_ptr.
  - wr_ptr increments modulo 2^LOG_ADDR_W.
  - A transition from all-ones to 0 sets has_wrapped.
- log_clear zeroes wr_ptr, has_wrapped and the counter. Any write already registered still completes the following cycle.
- The RAM write port always accepts; there is no backpressure.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - log_wr_req_val 0, log_wr_req_addr 0, log_wr_req_data 0
  - curr_log_wr_addr 0
  - has_wrapped 0
  - logging_active 0
- Entry sampled in cycle t:
  - log_wr_req_val=1 in cycle t+1, with addr = old wr_ptr and data = log_entry_data from cycle t.
  - curr_log_wr_addr = old wr_ptr+1 in cycle t+1.
  - has_wrapped rises in t+1 if that write used address 2^LOG_ADDR_W-1.
- log_start in cycle t: logging_active=1 at t+1. The first sample opportunity is cycle t+1+sample_interval.
- sample_interval=0: one write per cycle while log_entry_val is held high.
- log_stop in cycle t: the counter is in IDLE from t+1 and no new sample is taken in cycle t itself. A write sampled at t-1 still appears at t.
- Reset mid-operation: all state returns to reset values asynchronously, and any pending write is dropped.

## Configuration
- LOGGER_STOP_ON_FULL_EN defined (one-shot capture):
  - A write to address 2^LOG_ADDR_W-1 sets has_wrapped and moves the state to FULL.
  - FULL takes no further samples and ignores log_start and log_stop.
  - Only log_clear exits FULL, to IDLE.
  - In FULL, curr_log_wr_addr=0 and has_wrapped=1.
- Undefined (default): continuous circular overwrite. FULL is unreachable and is omitted from the enum.

## Structure
- logger_pkg holds:
  - the state enum (IDLE, LOGGING, FULL)
  - LOG_DATA_W=64
  - the command-priority encoding
  - the metadata layout shared with the read side: has_wrapped at bit LOG_ADDR_W, curr_log_wr_addr in bits LOG_ADDR_W-1:0
- One sub-module, logger_sample_timer: the interval counter. It has clk, rst and en inputs, a sample_interval input, and a sample_tick output.

## Test plan
- Reset, then log_start, sample_interval=3, log_entry_val held high -> writes to addr 0,1,2 spaced 4 cycles apart, with the first write 5 cycles after the log_start cycle; curr_log_wr_addr=3 after the third.
- sample_interval=0 with log_entry_val=1,0,1,1 -> writes to addr 0,1,2 only; the skipped cycle produces no strobe.
- LOG_ADDR_W=3 with 9 entries -> the 8th write to addr 7 sets has_wrapped; the 9th goes to addr 0; curr_log_wr_addr=1 and has_wrapped=1.
- log_start, log_stop and log_clear in the same cycle while LOGGING -> state IDLE, curr_log_wr_addr=0, has_wrapped=0.
- Stop after 2 entries, restart -> the next write goes to addr 2 and the counter restarts from 0.
- LOGGER_STOP_ON_FULL_EN defined, LOG_ADDR_W=3, 10 entries -> exactly 8 writes; state FULL; log_start is ignored; log_clear returns to IDLE with the pointer at 0.
